// File: rtl/fetch_queue.sv
// Prefetching fetch stage: streams instructions from instruction memory into a
// DEPTH-entry FIFO tagged with their PC, hands them to decode over valid/ready,
// and honours flush/redirect by dropping queued and in-flight instructions.
module fetch_queue #(
  parameter int unsigned   RW       = 16,
  parameter int unsigned   I_SIZE   = 32,
  parameter int unsigned   DEPTH    = 4,
  parameter int unsigned   ADDR_INC = 1,
  parameter logic [RW-1:0] RESET_PC = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  output logic [RW-1:0]              o_req_addr,
  output logic                       o_req_active,
  input  logic [I_SIZE-1:0]          i_req_data,
  input  logic                       i_req_data_valid,
  input  logic                       i_flush,
  input  logic [RW-1:0]              i_flush_addr,
  input  logic                       i_next_ready,
  output logic                       o_submit,
  output logic [I_SIZE-1:0]          o_instr,
  output logic [RW-1:0]              o_instr_pc,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [RW-1:0]     fetch_pc_q, fetch_pc_d;
  logic [RW-1:0]     req_addr_q, req_addr_d;
  logic              pending_q, pending_d;
  logic              drop_q, drop_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [I_SIZE-1:0] instr_mem_q [DEPTH];
  logic [RW-1:0]     pc_mem_q    [DEPTH];

  logic              req_active;
  logic [RW-1:0]     req_addr;
  logic              resp;
  logic              push;
  logic              pop;

  // Memory request and FIFO head presentation
  always_comb begin
    req_addr     = pending_q ? req_addr_q : fetch_pc_q;
    req_active   = !i_rst && (pending_q || (count_q < CW'(DEPTH)));
    resp         = req_active && i_req_data_valid;
    o_req_addr   = req_addr;
    o_req_active = req_active;
    o_submit     = (count_q != '0);
    o_instr      = instr_mem_q[rd_ptr_q];
    o_instr_pc   = pc_mem_q[rd_ptr_q];
    o_count      = count_q;
  end

  // Next-state logic: flush dominates, otherwise response/request and FIFO push/pop
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    pending_d  = pending_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (i_flush) begin
      fetch_pc_d = i_flush_addr;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      if (resp) begin
        pending_d = 1'b0;
        drop_d    = 1'b0;
      end else if (req_active) begin
        // An unanswered request (already pending or just raised) is held to
        // completion and its response discarded, so memory never sees the
        // address change mid-request.
        pending_d  = 1'b1;
        drop_d     = 1'b1;
        req_addr_d = req_addr;
      end
    end else begin
      pop = o_submit && i_next_ready;
      if (resp) begin
        pending_d = 1'b0;
        if (drop_q) begin
          drop_d = 1'b0;
        end else begin
          push       = 1'b1;
          fetch_pc_d = req_addr + RW'(ADDR_INC);
        end
      end else if (req_active && !pending_q) begin
        pending_d  = 1'b1;
        req_addr_d = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
      pending_q  <= 1'b0;
      drop_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage: instruction and the PC it was fetched from
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= i_req_data;
      pc_mem_q[wr_ptr_q]    <= req_addr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory model with programmable latency,
// scoreboard of expected PCs checked at every decode handshake.
module tb_fetch_queue;

  localparam int RW    = 16;
  localparam int IS    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] o_req_addr;
  logic          o_req_active;
  logic [IS-1:0] req_data;
  logic          req_valid;
  logic          flush = 1'b0;
  logic [RW-1:0] flush_addr = '0;
  logic          ready = 1'b0;
  logic          o_submit;
  logic [IS-1:0] o_instr;
  logic [RW-1:0] o_instr_pc;
  logic [CW-1:0] o_count;

  int vectors     = 0;
  int miscompares = 0;
  logic [RW-1:0] sb[$];
  int unsigned   lat      = 0;
  int unsigned   wait_cnt = 0;

  fetch_queue #(.RW(RW), .I_SIZE(IS), .DEPTH(DEPTH), .ADDR_INC(1), .RESET_PC(16'h0000)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_req_addr(o_req_addr), .o_req_active(o_req_active),
    .i_req_data(req_data), .i_req_data_valid(req_valid),
    .i_flush(flush), .i_flush_addr(flush_addr),
    .i_next_ready(ready), .o_submit(o_submit),
    .o_instr(o_instr), .o_instr_pc(o_instr_pc), .o_count(o_count)
  );

  always #5 clk = ~clk;

  // Memory: data encodes its address; valid after 'lat' cycles of request
  assign req_data  = {~o_req_addr, o_req_addr};
  assign req_valid = o_req_active && (wait_cnt >= lat);

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (o_req_active && !req_valid) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted instruction must match the next expected PC
  always @(negedge clk) begin
    logic [RW-1:0] e;
    if (!rst && !flush && o_submit && ready) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL sb_unexpected: observed pc %0h expected none", o_instr_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("instr_pc", 32'(o_instr_pc), 32'(e));
        check("instr", o_instr, {~e, e});
      end
    end
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task apply_reset;
    rst   = 1'b1;
    flush = 1'b0;
    ready = 1'b0;
    lat   = 0;
    sb.delete();
    repeat (2) tick;
  endtask

  task automatic drain(input string tag, input int budget, input int exp_cycles);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_drained"}, 32'(sb.size()), 0);
    if (exp_cycles >= 0) check({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_active", 32'(o_req_active), 0);
    check("rst_submit", 32'(o_submit), 0);
    check("rst_count", 32'(o_count), 0);
    check("rst_instr", o_instr, 0);
    check("rst_pc", 32'(o_instr_pc), 0);
    apply_reset;

    // 1: streaming, one instruction per cycle from cycle 2
    ready = 1'b1;
    for (int i = 0; i < 8; i++) sb.push_back(RW'(i));
    rst = 1'b0;
    #1;
    check("t1_addr0", 32'(o_req_addr), 0);
    check("t1_active", 32'(o_req_active), 1);
    check("t1_submit_c1", 32'(o_submit), 0);
    tick;
    check("t1_submit_c2", 32'(o_submit), 1);
    drain("t1", 20, 8);

    // 2: decode stalled, FIFO fills to DEPTH and requests stop
    apply_reset;
    rst = 1'b0;
    repeat (5) tick;
    #1;
    check("t2_count", 32'(o_count), 4);
    check("t2_active", 32'(o_req_active), 0);
    check("t2_addr", 32'(o_req_addr), 4);
    check("t2_submit", 32'(o_submit), 1);
    check("t2_head_pc", 32'(o_instr_pc), 0);
    check("t2_head_instr", o_instr, 32'hFFFF0000);
    for (int i = 0; i < 8; i++) sb.push_back(RW'(i));
    ready = 1'b1;
    drain("t2", 30, -1);

    // 3: flush during a pending slow fetch
    apply_reset;
    ready = 1'b1;
    lat   = 2;
    rst   = 1'b0;
    #1;
    check("t3_addr_c1", 32'(o_req_addr), 0);
    tick;
    flush      = 1'b1;
    flush_addr = 16'h0100;
    sb.push_back(16'h0100);
    sb.push_back(16'h0101);
    #1;
    check("t3_pend_addr", 32'(o_req_addr), 0);
    tick;
    flush = 1'b0;
    #1;
    check("t3_hold_addr", 32'(o_req_addr), 0);
    check("t3_hold_active", 32'(o_req_active), 1);
    check("t3_count", 32'(o_count), 0);
    check("t3_submit", 32'(o_submit), 0);
    tick;
    #1;
    check("t3_new_addr", 32'(o_req_addr), 32'h0100);
    drain("t3", 40, -1);

    // 4: flush coincident with response for address 5
    apply_reset;
    ready = 1'b1;
    rst   = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back(RW'(i));
    sb.push_back(16'h0200);
    sb.push_back(16'h0201);
    repeat (5) tick;
    flush      = 1'b1;
    flush_addr = 16'h0200;
    #1;
    check("t4_addr", 32'(o_req_addr), 5);
    check("t4_active", 32'(o_req_active), 1);
    tick;
    flush = 1'b0;
    #1;
    check("t4_next_addr", 32'(o_req_addr), 32'h0200);
    check("t4_count", 32'(o_count), 0);
    drain("t4", 30, -1);

    // 5: simultaneous push and pop at count 2
    apply_reset;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) sb.push_back(RW'(i));
    tick;
    tick;
    ready = 1'b1;
    #1;
    check("t5_count_a", 32'(o_count), 2);
    check("t5_head_a", 32'(o_instr_pc), 0);
    tick;
    #1;
    check("t5_count_b", 32'(o_count), 2);
    check("t5_head_b", 32'(o_instr_pc), 1);
    tick;
    #1;
    check("t5_count_c", 32'(o_count), 2);
    drain("t5", 30, -1);

    // 6: PC wrap and asynchronous reset while pending
    apply_reset;
    ready      = 1'b1;
    rst        = 1'b0;
    flush      = 1'b1;
    flush_addr = 16'hFFFF;
    sb.push_back(16'hFFFF);
    sb.push_back(16'h0000);
    tick;
    flush = 1'b0;
    #1;
    check("t6_addr_ffff", 32'(o_req_addr), 32'hFFFF);
    check("t6_count_drop", 32'(o_count), 0);
    tick;
    #1;
    check("t6_wrap_addr", 32'(o_req_addr), 0);
    tick;
    lat = 5;
    #1;
    check("t6_addr1", 32'(o_req_addr), 1);
    tick;
    #1;
    check("t6_pend_addr", 32'(o_req_addr), 1);
    check("t6_pend_active", 32'(o_req_active), 1);
    check("t6_sb_empty", 32'(sb.size()), 0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_active", 32'(o_req_active), 0);
    check("t6_rst_submit", 32'(o_submit), 0);
    check("t6_rst_count", 32'(o_count), 0);
    tick;
    lat = 0;
    rst = 1'b0;
    #1;
    check("t6_restart_addr", 32'(o_req_addr), 0);
    check("t6_restart_active", 32'(o_req_active), 1);
    rst = 1'b1;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
